pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle processor, successor to the plain PC register. Holds the current instruction address and on each clock selects the next one: sequential step, PC-relative branch, absolute jump, or call/return through an optional return-address stack (RAS). Adds stall (hold) capability and asynchronous reset to a defined vector. Sits at the front of the datapath and feeds instruction memory and the branch adder.

## Interface
- WIDTH, 32: address width in bits.
- RESET_VECTOR, 0: PC value loaded on reset.
- STEP, 4: sequential increment, in bytes.
- RAS_DEPTH, 4: RAS entries; power of two, at least 2.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- branch_taken  in  1  take PC-relative branch.
- branch_offset  in  WIDTH  signed byte offset added to the current PC.
- jump  in  1  absolute jump to jump_target.
- call  in  1  jump to jump_target and push return address.
- ret  in  1  return to address on RAS top.
- jump_target  in  WIDTH  absolute target for jump/call.
- salida  out  WIDTH  current PC (registered).
- pc_plus_step  out  WIDTH  salida + STEP (combinational).
- ras_empty  out  1  RAS holds no entries (registered).
- ras_full  out  1  RAS holds RAS_DEPTH entries (registered).
- ras_err  out  1  one-cycle pulse: ret on empty RAS, or push onto full RAS.

## Operation
- Reset (asynchronous, while rst_n = 0): salida = RESET_VECTOR, RAS count = 0, top pointer = 0, ras_empty = 1, ras_full = 0, ras_err = 0. RAS entry contents are don't-care.
- Next-PC priority, highest first:
  - stall: everything holds; ras_err = 0.
  - ret: RAS non-empty gives salida <= top entry, then pop. RAS empty gives salida <= salida + STEP and ras_err = 1.
  - call: salida <= jump_target; push salida + STEP.
  - jump: salida <= jump_target.
  - branch_taken: salida <= salida + branch_offset.
  - otherwise: salida <= salida + STEP.
- call and ret in the same cycle: ret supplies the next PC.
  - Non-empty RAS: the top entry is replaced by salida + STEP; count unchanged; no ras_err.
  - Empty RAS: salida <= salida + STEP, push salida + STEP (count becomes 1), ras_err = 1.
- Push onto a full RAS is circular: the pointer advances, the oldest entry is overwritten, count stays RAS_DEPTH, and ras_err = 1 that cycle.
- Pointer arithmetic is modulo RAS_DEPTH.
- All address arithmetic is modulo 2^WIDTH. Wrap-around is silent and not an error. branch_offset is two's complement.
- No alignment checking; targets are used as given.

## Timing
- One-cycle latency: control inputs sampled at a rising edge take effect in salida on the same edge. The new value is visible for the whole following cycle.
- pc_plus_step follows salida combinationally within the same cycle.
- ras_empty, ras_full and ras_err update on the same edge as salida. ras_err stays high for exactly one cycle per event.
- rst_n assertion mid-cycle forces reset values immediately, with no clock needed. Deassertion is synchronised by the user; the first update occurs on the first rising edge with rst_n = 1.
- No handshake: the unit accepts a new control set every non-stalled cycle.

## Configuration
- PC_RAS_EN defined: the RAS is built as described above.
- PC_RAS_EN undefined:
  - No storage or pointer logic.
  - call behaves exactly as jump.
  - ret is ignored and falls through to the lower-priority sources.
  - ras_empty is tied to 1, ras_full to 0 and ras_err to 0.

## Test plan
- Reset and step: hold rst_n = 0, then release with defaults. salida = 0x0 after reset, then 0x4, 0x8, 0xC on successive edges. pc_plus_step = 0x10 while salida = 0xC.
- Branch and stall: at salida = 0x100, apply branch_taken with offset 0xFFFFFFF0, giving salida = 0x0F0. Assert stall for 3 cycles: salida stays 0x0F0. Apply jump with target 0x8000: salida = 0x8000.
- Call/return nesting:
  - At 0x20, call to 0x400; at 0x400, call to 0x800.
  - ret gives 0x404, then a second ret gives 0x24, then ras_empty = 1.
  - A third ret gives 0x28 with a ras_err pulse of exactly one cycle.
- Overflow: with RAS_DEPTH = 4, perform 5 calls from 0x0, 0x100, 0x200, 0x300, 0x400 (each to the next address).
  - ras_full = 1 and ras_err pulses on the 5th call.
  - Four rets return 0x404, 0x304, 0x204, 0x104; 0x4 is lost.
- Simultaneous call+ret and async reset:
  - At 0x500 with top = 0x104, assert call+ret: salida = 0x104, top becomes 0x504, count unchanged.
  - Then pulse rst_n low between edges: salida = 0x0 and ras_empty = 1 immediately.
  - Rerun the call/return test with PC_RAS_EN undefined: call reaches the target, ret steps by 4, ras_err is never asserted.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter selecting step, PC-relative branch, jump, or call/return.
// The return-address stack is built only when PC_RAS_EN is defined; otherwise call acts as jump
// and ret is ignored.
module pc_unit #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int STEP = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] salida,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] pc_next;

    assign pc_plus_step = salida + WIDTH'(STEP);

`ifdef PC_RAS_EN
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    wr_idx;
    logic [PW:0]      cnt;
    logic [PW:0]      cnt_next;
    logic             ret_hit;
    logic             push;
    logic             repl;
    logic             pop;
    logic             err_next;

    // Decode the RAS operation (push, pop, replace top) and pick the next PC by priority.
    always_comb begin
        ret_hit  = ret && !ras_empty;
        push     = call && !ret_hit;
        repl     = call && ret_hit;
        pop      = ret_hit && !call;
        err_next = (ret && ras_empty) || (push && ras_full);
        wr_idx   = push ? ptr + PW'(1) : ptr;
        ptr_next = push ? ptr + PW'(1) : pop ? ptr - PW'(1) : ptr;
        cnt_next = (push && !ras_full) ? cnt + (PW+1)'(1) : pop ? cnt - (PW+1)'(1) : cnt;
        pc_next  = ret ? (ret_hit ? ras[ptr] : pc_plus_step) :
                   (call || jump) ? jump_target :
                   branch_taken ? salida + branch_offset : pc_plus_step;
    end

    // PC and stack bookkeeping; stall freezes all state and masks the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            salida    <= RESET_VECTOR;
            ptr       <= '0;
            cnt       <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_err   <= 1'b0;
        end else begin
            ras_err <= !stall && err_next;
            if (!stall) begin
                salida    <= pc_next;
                ptr       <= ptr_next;
                cnt       <= cnt_next;
                ras_empty <= cnt_next == '0;
                ras_full  <= cnt_next == (PW+1)'(RAS_DEPTH);
            end
        end
    end

    // Entry storage has no reset; a full-stack push lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (rst_n && !stall && (push || repl))
            ras[wr_idx] <= pc_plus_step;
    end
`else
    logic [PW:0] unused_ras;

    assign unused_ras = {ret, {PW{1'b0}}};
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;

    // Without a stack, call degenerates to jump and ret falls through.
    always_comb begin
        pc_next = (call || jump) ? jump_target :
                  branch_taken ? salida + branch_offset : pc_plus_step;
    end

    // PC register; stall holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            salida <= RESET_VECTOR;
        else if (!stall)
            salida <= pc_next;
    end
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; expectations follow PC_RAS_EN when it is defined.
module tb_pc_unit;
`ifdef PC_RAS_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] salida;
    logic [31:0] pc_plus_step;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;

    pc_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_offset(branch_offset),
        .jump(jump),
        .call(call),
        .ret(ret),
        .jump_target(jump_target),
        .salida(salida),
        .pc_plus_step(pc_plus_step),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    endtask

    task automatic push_exp(input string nm, input logic [31:0] epc, input logic ee, input logic ef, input logic eer);
        exp_t x;
        x.name = nm;
        x.pc = epc;
        x.e = ee;
        x.f = ef;
        x.er = eer;
        q.push_back(x);
    endtask

    task automatic cyc(input string nm, input logic st, input logic br, input logic [31:0] off,
                       input logic jp, input logic cl, input logic rt, input logic [31:0] tgt,
                       input logic [31:0] epc, input logic ee, input logic ef, input logic eer);
        stall = st;
        branch_taken = br;
        branch_offset = off;
        jump = jp;
        call = cl;
        ret = rt;
        jump_target = tgt;
        @(posedge clk);
        push_exp(nm, epc, ee, ef, eer);
        @(negedge clk);
    endtask

    // Monitor: outputs are stable between edges, so compare on the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk(x.name, "pc", salida, x.pc);
                chk(x.name, "pps", pc_plus_step, x.pc + 32'd4);
                chk(x.name, "empty", {31'b0, ras_empty}, {31'b0, x.e});
                chk(x.name, "full", {31'b0, ras_full}, {31'b0, x.f});
                chk(x.name, "err", {31'b0, ras_err}, {31'b0, x.er});
            end
        end
    end

    initial begin
        #1 push_exp("reset", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("step1", 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
        cyc("step2", 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 0);
        cyc("step3", 0, 0, 0, 0, 0, 0, 0, 32'hC, 1, 0, 0);
        cyc("jmp100", 0, 0, 0, 1, 0, 0, 32'h100, 32'h100, 1, 0, 0);
        cyc("br_back", 0, 1, 32'hFFFFFFF0, 0, 0, 0, 0, 32'hF0, 1, 0, 0);
        cyc("stall1", 1, 1, 32'h40, 1, 1, 1, 32'h1234, 32'hF0, 1, 0, 0);
        cyc("stall2", 1, 1, 32'h40, 1, 1, 1, 32'h1234, 32'hF0, 1, 0, 0);
        cyc("stall3", 1, 1, 32'h40, 1, 1, 1, 32'h1234, 32'hF0, 1, 0, 0);
        cyc("jmp8000", 0, 0, 0, 1, 0, 0, 32'h8000, 32'h8000, 1, 0, 0);
        cyc("jmp20", 0, 0, 0, 1, 0, 0, 32'h20, 32'h20, 1, 0, 0);
        cyc("call400", 0, 0, 0, 0, 1, 0, 32'h400, 32'h400, !R, 0, 0);
        cyc("call800", 0, 0, 0, 0, 1, 0, 32'h800, 32'h800, !R, 0, 0);
        cyc("ret1", 0, 0, 0, 0, 0, 1, 0, R ? 32'h404 : 32'h804, !R, 0, 0);
        cyc("ret2", 0, 0, 0, 0, 0, 1, 0, R ? 32'h24 : 32'h808, 1, 0, 0);
        cyc("ret3", 0, 0, 0, 0, 0, 1, 0, R ? 32'h28 : 32'h80C, 1, 0, R);
        cyc("err_clr", 0, 0, 0, 0, 0, 0, 0, R ? 32'h2C : 32'h810, 1, 0, 0);
        cyc("jmp0", 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
        cyc("ovf_c1", 0, 0, 0, 0, 1, 0, 32'h100, 32'h100, !R, 0, 0);
        cyc("ovf_c2", 0, 0, 0, 0, 1, 0, 32'h200, 32'h200, !R, 0, 0);
        cyc("ovf_c3", 0, 0, 0, 0, 1, 0, 32'h300, 32'h300, !R, 0, 0);
        cyc("ovf_c4", 0, 0, 0, 0, 1, 0, 32'h400, 32'h400, !R, R, 0);
        cyc("ovf_c5", 0, 0, 0, 0, 1, 0, 32'h500, 32'h500, !R, R, R);
        cyc("ovf_r1", 0, 0, 0, 0, 0, 1, 0, R ? 32'h404 : 32'h504, !R, 0, 0);
        cyc("ovf_r2", 0, 0, 0, 0, 0, 1, 0, R ? 32'h304 : 32'h508, !R, 0, 0);
        cyc("ovf_r3", 0, 0, 0, 0, 0, 1, 0, R ? 32'h204 : 32'h50C, !R, 0, 0);
        cyc("jmp500", 0, 0, 0, 1, 0, 0, 32'h500, 32'h500, !R, 0, 0);
        cyc("callret", 0, 0, 0, 0, 1, 1, 32'h700, R ? 32'h104 : 32'h700, !R, 0, 0);
        cyc("ret_repl", 0, 0, 0, 0, 0, 1, 0, R ? 32'h504 : 32'h704, 1, 0, 0);
        cyc("ret_lost", 0, 0, 0, 0, 0, 1, 0, R ? 32'h508 : 32'h708, 1, 0, R);
        cyc("callret_e", 0, 0, 0, 0, 1, 1, 32'h900, R ? 32'h50C : 32'h900, !R, 0, R);
        cyc("ret_pushd", 0, 0, 0, 0, 0, 1, 0, R ? 32'h50C : 32'h904, 1, 0, 0);
        cyc("callA00", 0, 0, 0, 0, 1, 0, 32'hA00, 32'hA00, !R, 0, 0);
        call = 1'b0;
        jump_target = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        push_exp("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
